// File: rtl/nbcac_22di_decoder_seq.sv
// Multi-cycle NBCAC 22-bit decoder: rebuilds v = sum(d[i]*s[i]) from a 31-bit codeword, BPC bits per cycle.
// Optional range check on the final sum is enabled by defining NBCAC_DEC_RANGE_CHK_EN.
module nbcac_22di_decoder_seq #(
  parameter int BPC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [21:0] out_data,
  output logic        out_err
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and data is held while stalled.

  localparam int         N    = (31 + BPC - 1) / BPC;
  localparam logic [4:0] LAST = 5'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [30:0] r_code;
  logic [4:0]  r_chunk;
  logic [22:0] r_acc;
  logic [22:0] w_chunk_sum;
  logic [22:0] w_acc_next;
  logic        w_over;

  // Encoder weight table; k is the zero-based codeword bit index (k = i-1).
  function automatic logic [22:0] weight(input logic [4:0] k);
    case (k)
      5'd0:    weight = 23'd1;
      5'd1:    weight = 23'd1664080;
      5'd2:    weight = 23'd1028458;
      5'd3:    weight = 23'd635622;
      5'd4:    weight = 23'd392836;
      5'd5:    weight = 23'd242786;
      5'd6:    weight = 23'd150050;
      5'd7:    weight = 23'd92736;
      5'd8:    weight = 23'd57314;
      5'd9:    weight = 23'd35422;
      5'd10:   weight = 23'd21892;
      5'd11:   weight = 23'd13530;
      5'd12:   weight = 23'd8362;
      5'd13:   weight = 23'd5168;
      5'd14:   weight = 23'd3194;
      5'd15:   weight = 23'd1974;
      5'd16:   weight = 23'd1220;
      5'd17:   weight = 23'd754;
      5'd18:   weight = 23'd466;
      5'd19:   weight = 23'd288;
      5'd20:   weight = 23'd178;
      5'd21:   weight = 23'd110;
      5'd22:   weight = 23'd68;
      5'd23:   weight = 23'd42;
      5'd24:   weight = 23'd26;
      5'd25:   weight = 23'd16;
      5'd26:   weight = 23'd10;
      5'd27:   weight = 23'd6;
      5'd28:   weight = 23'd4;
      5'd29:   weight = 23'd2;
      5'd30:   weight = 23'd2;
      default: weight = 23'd0;
    endcase
  endfunction

  // Weighted sum of the current chunk; bit positions past the last codeword bit add nothing.
  always_comb begin
    w_chunk_sum = '0;
    for (int j = 0; j < BPC; j++) begin
      if (int'(r_chunk) * BPC + j < 31) begin
        if (r_code[5'(int'(r_chunk) * BPC + j)]) begin
          w_chunk_sum = w_chunk_sum + weight(5'(int'(r_chunk) * BPC + j));
        end
      end
    end
  end

  assign w_acc_next = r_acc + w_chunk_sum;

`ifdef NBCAC_DEC_RANGE_CHK_EN
  assign w_over = (w_acc_next > 23'd4194303);
`else
  assign w_over = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_code    <= '0;
      r_chunk   <= '0;
      r_acc     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_code   <= in_code;
            r_acc    <= '0;
            r_chunk  <= '0;
            in_ready <= 1'b0;
            r_state  <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc <= w_acc_next;
          if (r_chunk == LAST) begin
            out_data  <= w_acc_next[21:0];
            out_err   <= w_over;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_chunk <= r_chunk + 5'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbcac_22di_decoder_seq.sv
// Directed bench for nbcac_22di_decoder_seq: three instances (BPC=4, 31, 1) share the inputs.
// Expected values are hand-computed from the weight table; out_err expectations follow NBCAC_DEC_RANGE_CHK_EN.
module tb_nbcac_22di_decoder_seq;

`ifdef NBCAC_DEC_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam int LAT0 = 8;
  localparam int LAT1 = 1;
  localparam int LAT2 = 31;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [30:0] in_code;
  logic        out_ready;
  logic [2:0]  ov;
  logic [2:0]  ir;
  logic [2:0]  oe;
  logic [21:0] od0, od1, od2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [30:0] code;
    logic [21:0] data;
    logic        over;
  } vec_t;

  vec_t vecs[14];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  nbcac_22di_decoder_seq #(.BPC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_code(in_code),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0), .out_err(oe[0])
  );
  nbcac_22di_decoder_seq #(.BPC(31)) u_dut31 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_code(in_code),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1), .out_err(oe[1])
  );
  nbcac_22di_decoder_seq #(.BPC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_code(in_code),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2), .out_err(oe[2])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Apply one codeword, measure per-instance latency, check results, then release.
  task automatic run_vec(input logic [30:0] code, input logic [21:0] exp_d, input logic over,
                         input string nm);
    int  lat[3];
    logic exp_e;
    exp_e = over & CHK;
    for (int k = 0; k < 3; k++) lat[k] = 0;
    chk({nm, " in_ready before"}, {29'd0, ir}, 32'd7);
    in_code  = code;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_code  = 31'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) if (lat[k] == 0 && ov[k]) lat[k] = cyc;
    end
    chk({nm, " lat bpc4"},  lat[0], LAT0);
    chk({nm, " lat bpc31"}, lat[1], LAT1);
    chk({nm, " lat bpc1"},  lat[2], LAT2);
    chk({nm, " data bpc4"},  {10'd0, od0}, {10'd0, exp_d});
    chk({nm, " data bpc31"}, {10'd0, od1}, {10'd0, exp_d});
    chk({nm, " data bpc1"},  {10'd0, od2}, {10'd0, exp_d});
    chk({nm, " err"}, {29'd0, oe}, {29'd0, {3{exp_e}}});
    chk({nm, " in_ready in done"}, {29'd0, ir}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " out_valid after take"}, {29'd0, ov}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{31'h0000_0000, 22'd0,       1'b0};
    vecs[1]  = '{31'h0000_0001, 22'd1,       1'b0};
    vecs[2]  = '{31'h0000_0002, 22'd1664080, 1'b0};
    vecs[3]  = '{31'h4000_0000, 22'd2,       1'b0};
    vecs[4]  = '{31'h6000_0000, 22'd4,       1'b0};
    vecs[5]  = '{31'h7FFF_FFFF, 22'd162313,  1'b1};
    vecs[6]  = '{31'h7FFF_FFFE, 22'd162312,  1'b1};
    vecs[7]  = '{31'h0000_00FE, 22'd12264,   1'b1};
    vecs[8]  = '{31'h0000_007E, 22'd4113832, 1'b0};
    vecs[9]  = '{31'h0000_FF00, 22'd146856,  1'b0};
    vecs[10] = '{31'h5555_5555, 22'd1664081, 1'b0};
    vecs[11] = '{31'h2AAA_AAAA, 22'd2692536, 1'b0};
    vecs[12] = '{31'h0000_000F, 22'd3328161, 1'b0};
    vecs[13] = '{31'h0000_0010, 22'd392836,  1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset out_valid", {29'd0, ov}, 32'd0);
    chk("reset in_ready",  {29'd0, ir}, 32'd7);
    chk("reset out_err",   {29'd0, oe}, 32'd0);
    chk("reset out_data",  {10'd0, od0 | od1 | od2}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i].code, vecs[i].data, vecs[i].over, $sformatf("vec%0d", i));
    end

    // Stall in DONE for 20 cycles while in_valid/in_code toggle.
    in_code  = 31'h0000_007E;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT2) @(posedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      in_valid = ~in_valid;
      in_code  = 31'($urandom);
      @(posedge clk); #1;
      chk($sformatf("stall%0d valid", c), {29'd0, ov}, 32'd7);
      chk($sformatf("stall%0d ready", c), {29'd0, ir}, 32'd0);
      chk($sformatf("stall%0d data", c), {10'd0, od0 ^ od1 ^ od2}, 32'd4113832);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall release valid", {29'd0, ov}, 32'd0);
    chk("stall release ready", {29'd0, ir}, 32'd7);

    // Reset at ACC chunk 3 of the BPC=4 instance drops the word.
    in_code  = 31'h7FFF_FFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset bpc4 busy", {31'd0, ov[0] | ir[0]}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midreset out_valid", {29'd0, ov}, 32'd0);
    chk("midreset in_ready",  {29'd0, ir}, 32'd7);
    chk("midreset out_data",  {10'd0, od0 | od1 | od2}, 32'd0);
    run_vec(31'h0000_0002, 22'd1664080, 1'b0, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
